// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one byte-wide memory port between the core and the
//            memory manager (loader/debug). Ownership changes only at core
//            instruction boundaries (core_cede). Halt mode keeps the core
//            stopped so the loader can fill memory. A sticky watchdog flags
//            a core that never cedes.
// Ports    : clk, rst_n            clock, async active-low reset
//            o_core_state          run-enable to core
//            i_core_cede/we/wd/ad  core handshake and memory request
//            i_mgr_req, o_mgr_gnt  manager request/grant (level)
//            i_mgr_we/wd/ad        manager memory request
//            i_halt                keep core stopped while manager is idle
//            i_mem_rd, o_rd_out    read data, fanned out to both requesters
//            o_mem_we/wd/ad        external memory port
//            o_fsm                 state encoding for LEDs/debug
//            o_cede_timeout        sticky watchdog flag
// Params   : MABL address width, CEDE_TIMEOUT (>= 2) DRAIN cycles before the
//            watchdog fires, TW counter width (2**TW > CEDE_TIMEOUT).
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int MABL         = 19,
  parameter int CEDE_TIMEOUT = 1024,
  parameter int TW           = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_core_state,
  input  logic            i_core_cede,
  input  logic            i_core_we,
  input  logic [7:0]      i_core_wd,
  input  logic [MABL-1:0] i_core_ad,
  input  logic            i_mgr_req,
  output logic            o_mgr_gnt,
  input  logic            i_mgr_we,
  input  logic [7:0]      i_mgr_wd,
  input  logic [MABL-1:0] i_mgr_ad,
  input  logic            i_halt,
  input  logic [7:0]      i_mem_rd,
  output logic            o_mem_we,
  output logic [7:0]      o_mem_wd,
  output logic [MABL-1:0] o_mem_ad,
  output logic [7:0]      o_rd_out,
  output logic [2:0]      o_fsm,
  output logic            o_cede_timeout
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_CORE_RUN = 3'd1;
  localparam logic [2:0] c_DRAIN    = 3'd2;
  localparam logic [2:0] c_MGR_OWN  = 3'd3;
  localparam logic [2:0] c_HANDBACK = 3'd4;

  localparam logic [TW-1:0] c_SAT  = TW'(CEDE_TIMEOUT);
  // The flag sets on the edge that completes the CEDE_TIMEOUT-th DRAIN cycle,
  // i.e. when the count before that edge is CEDE_TIMEOUT-1. Comparing against
  // the pre-increment value also avoids any wrap of count+1.
  localparam logic [TW-1:0] c_LAST = TW'(CEDE_TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [TW-1:0] r_wdog;
  logic          r_timeout;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (i_mgr_req)    w_next = c_MGR_OWN;
        else if (!i_halt) w_next = c_CORE_RUN;
      end
      c_CORE_RUN: begin
        if (i_mgr_req || i_halt) w_next = c_DRAIN;
      end
      c_DRAIN: begin
        if (i_core_cede && i_mgr_req)          w_next = c_MGR_OWN;
        else if (i_core_cede && i_halt)        w_next = c_IDLE;
        // Reason to stop vanished: resume the core even if it already ceded.
        else if (!i_mgr_req && !i_halt)        w_next = c_CORE_RUN;
      end
      c_MGR_OWN: begin
        if (!i_mgr_req) w_next = c_HANDBACK;
      end
      c_HANDBACK: begin
        if (i_mgr_req)   w_next = c_MGR_OWN;
        else if (i_halt) w_next = c_IDLE;
        else             w_next = c_CORE_RUN;
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Cede watchdog: counts consecutive cycles in DRAIN, zero elsewhere.
  // It only reports; ownership is never forced.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == c_DRAIN && w_next == c_DRAIN)
        r_wdog <= (r_wdog == c_SAT) ? r_wdog : r_wdog + TW'(1);
      else
        r_wdog <= '0;
      if (r_state == c_DRAIN && r_wdog >= c_LAST)
        r_timeout <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs. The memory mux is decoded from the state register only, so
  // a single source (or none) reaches mem_we and the async reset clears the
  // strobe as soon as rst_n falls.
  // --------------------------------------------------------------------------
  always_comb begin
    o_mem_we = 1'b0;
    o_mem_wd = '0;
    o_mem_ad = '0;
    case (r_state)
      c_CORE_RUN, c_DRAIN: begin
        o_mem_we = i_core_we;
        o_mem_wd = i_core_wd;
        o_mem_ad = i_core_ad;
      end
      c_MGR_OWN: begin
        o_mem_we = i_mgr_we;
        o_mem_wd = i_mgr_wd;
        o_mem_ad = i_mgr_ad;
      end
      default: begin
        o_mem_we = 1'b0;
        o_mem_wd = '0;
        o_mem_ad = '0;
      end
    endcase
  end

  assign o_core_state   = (r_state == c_CORE_RUN);
  assign o_mgr_gnt      = (r_state == c_MGR_OWN);
  assign o_rd_out       = i_mem_rd;
  assign o_fsm          = r_state;
  assign o_cede_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a behavioural model of
//            ownership, the memory mux and the cede watchdog.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int MABL = 19;
  localparam int TO   = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_DRAIN = 3'd2, S_MGR = 3'd3, S_HB = 3'd4
  } st_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            core_cede = 1'b0, core_we = 1'b0;
  logic [7:0]      core_wd = '0;
  logic [MABL-1:0] core_ad = '0;
  logic            mgr_req = 1'b0, mgr_we = 1'b0;
  logic [7:0]      mgr_wd = '0;
  logic [MABL-1:0] mgr_ad = '0;
  logic            halt = 1'b0;
  logic [7:0]      mem_rd = '0;
  logic            o_core_state, o_mgr_gnt, o_mem_we, o_cede_timeout;
  logic [7:0]      o_mem_wd, o_rd_out;
  logic [MABL-1:0] o_mem_ad;
  logic [2:0]      o_fsm;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state
  st_t m_st    = S_IDLE;
  int  m_drain = 0;
  bit  m_flag  = 1'b0;

  mem_arbiter #(.MABL(MABL), .CEDE_TIMEOUT(TO), .TW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_core_state(o_core_state), .i_core_cede(core_cede), .i_core_we(core_we),
    .i_core_wd(core_wd), .i_core_ad(core_ad),
    .i_mgr_req(mgr_req), .o_mgr_gnt(o_mgr_gnt), .i_mgr_we(mgr_we),
    .i_mgr_wd(mgr_wd), .i_mgr_ad(mgr_ad), .i_halt(halt),
    .i_mem_rd(mem_rd), .o_mem_we(o_mem_we), .o_mem_wd(o_mem_wd),
    .o_mem_ad(o_mem_ad), .o_rd_out(o_rd_out), .o_fsm(o_fsm),
    .o_cede_timeout(o_cede_timeout)
  );

  always #5 clk = ~clk;

  // Ownership rules as a plain decision table on named states.
  function automatic st_t model_next();
    case (m_st)
      S_IDLE:  return mgr_req ? S_MGR : (!halt ? S_RUN : S_IDLE);
      S_RUN:   return (mgr_req || halt) ? S_DRAIN : S_RUN;
      S_DRAIN: begin
        if (core_cede && mgr_req) return S_MGR;
        if (core_cede && halt)    return S_IDLE;
        if (!mgr_req && !halt)    return S_RUN;
        return S_DRAIN;
      end
      S_MGR:   return mgr_req ? S_MGR : S_HB;
      default: return mgr_req ? S_MGR : (halt ? S_IDLE : S_RUN);
    endcase
  endfunction

  function automatic logic [41:0] exp_outs();
    logic            we;
    logic [7:0]      wd;
    logic [MABL-1:0] ad;
    we = 1'b0; wd = '0; ad = '0;
    if (m_st == S_RUN || m_st == S_DRAIN) begin
      we = core_we; wd = core_wd; ad = core_ad;
    end else if (m_st == S_MGR) begin
      we = mgr_we; wd = mgr_wd; ad = mgr_ad;
    end
    return {3'(m_st), m_st == S_RUN, m_st == S_MGR, we, wd, ad, mem_rd, m_flag};
  endfunction

  function automatic logic [41:0] dut_outs();
    return {o_fsm, o_core_state, o_mgr_gnt, o_mem_we, o_mem_wd, o_mem_ad,
            o_rd_out, o_cede_timeout};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_drain = 0; m_flag = 1'b0;
  endtask

  // One clock edge for DUT and model; returns 1 time unit after the edge.
  task automatic tick();
    st_t nx;
    nx = model_next();
    @(posedge clk); #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_st == S_DRAIN) begin
        m_drain++;
        if (m_drain >= TO) m_flag = 1'b1;
      end
      if (nx != S_DRAIN) m_drain = 0;
      m_st = nx;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b0; mgr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1; model_reset(); #1;
    n_chk++;
    if (dut_outs() !== exp_outs())
      $display("FAIL reset_outs: got %h expected %h", dut_outs(), exp_outs());
    else n_pass++;
    rst_n = 1'b1;
    tick(); #1;
    n_chk++;
    if ({o_fsm, o_core_state} !== {3'd1, 1'b1})
      $display("FAIL reset_release: got fsm=%0d cs=%0b expected fsm=1 cs=1", o_fsm, o_core_state);
    else n_pass++;
    core_ad = 19'h00010; core_wd = 8'hA5; core_we = 1'b1; #1;
    n_chk++;
    if ({o_mem_ad, o_mem_wd, o_mem_we} !== {19'h00010, 8'hA5, 1'b1})
      $display("FAIL core_write: got ad=%h wd=%h we=%b expected ad=00010 wd=a5 we=1", o_mem_ad, o_mem_wd, o_mem_we);
    else n_pass++;
  endtask

  task automatic test_drain_handoff();
    mgr_req = 1'b1; core_cede = 1'b0; mgr_we = 1'b1; mgr_ad = 19'h12345;
    for (int i = 0; i < 5; i++) begin
      tick();
      core_ad = MABL'($urandom); core_we = 1'(($urandom)); #1;
      n_chk++;
      if ({o_core_state, o_mgr_gnt, o_fsm, o_mem_ad} !== {1'b0, 1'b0, 3'd2, core_ad})
        $display("FAIL drain_wait[%0d]: got cs=%b gnt=%b fsm=%0d ad=%h expected cs=0 gnt=0 fsm=2 ad=%h",
                 i, o_core_state, o_mgr_gnt, o_fsm, o_mem_ad, core_ad);
      else n_pass++;
    end
    core_cede = 1'b1;
    tick();
    mgr_ad = 19'h7FFFF; mgr_wd = 8'h3C; mgr_we = 1'b1; #1;
    n_chk++;
    if ({o_mgr_gnt, o_mem_ad, o_mem_wd, o_mem_we} !== {1'b1, 19'h7FFFF, 8'h3C, 1'b1})
      $display("FAIL mgr_write: got gnt=%b ad=%h wd=%h we=%b expected gnt=1 ad=7ffff wd=3c we=1",
               o_mgr_gnt, o_mem_ad, o_mem_wd, o_mem_we);
    else n_pass++;
    n_chk++;
    if (dut_outs() !== exp_outs())
      $display("FAIL mgr_own_model: got %h expected %h", dut_outs(), exp_outs());
    else n_pass++;
  endtask

  task automatic test_handback();
    mgr_req = 1'b0;
    tick();
    mgr_we = 1'b1; core_we = 1'b1; mgr_ad = 19'h00abc; core_ad = 19'h00def; #1;
    n_chk++;
    if ({o_fsm, o_mem_we, o_mem_ad} !== {3'd4, 1'b0, 19'h0})
      $display("FAIL handback: got fsm=%0d we=%b ad=%h expected fsm=4 we=0 ad=0", o_fsm, o_mem_we, o_mem_ad);
    else n_pass++;
    tick(); #1;
    n_chk++;
    if (o_core_state !== 1'b1)
      $display("FAIL handback_resume: got cs=%b expected 1", o_core_state);
    else n_pass++;
  endtask

  task automatic test_halt_loader();
    logic [2:0] seq [10];
    bit ran;
    seq = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    ran = 1'b0;
    rst_n = 1'b0; halt = 1'b1; mgr_req = 1'b1; mgr_we = 1'b0; core_we = 1'b0;
    @(posedge clk); #1; model_reset();
    rst_n = 1'b1; #1;
    n_chk++;
    if (o_fsm !== 3'd0) $display("FAIL halt_start: got fsm=%0d expected 0", o_fsm);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      mgr_req = (i < 8);
      tick(); #1;
      if (o_core_state) ran = 1'b1;
      n_chk++;
      if (o_fsm !== seq[i]) $display("FAIL halt_seq[%0d]: got fsm=%0d expected %0d", i, o_fsm, seq[i]);
      else n_pass++;
    end
    n_chk++;
    if (ran) $display("FAIL halt_core_ran: got core_state=1 expected never 1");
    else n_pass++;
    halt = 1'b0;
    tick(); #1;
    n_chk++;
    if (o_fsm !== 3'd1) $display("FAIL halt_release: got fsm=%0d expected 1", o_fsm);
    else n_pass++;
  endtask

  task automatic test_timeout();
    rst_n = 1'b0; #2; model_reset(); rst_n = 1'b1;
    halt = 1'b0; mgr_req = 1'b0; core_cede = 1'b0;
    tick();                         // -> CORE_RUN
    halt = 1'b1;
    tick();                         // -> DRAIN
    for (int i = 1; i <= TO; i++) begin
      tick(); #1;
      n_chk++;
      if (o_cede_timeout !== (i >= TO))
        $display("FAIL timeout_cnt[%0d]: got %b expected %b", i, o_cede_timeout, i >= TO);
      else n_pass++;
    end
    mgr_req = 1'b1; core_cede = 1'b1;
    repeat (3) tick();
    #1;
    n_chk++;
    if ({o_fsm, o_cede_timeout} !== {3'd3, 1'b1})
      $display("FAIL timeout_sticky: got fsm=%0d to=%b expected fsm=3 to=1", o_fsm, o_cede_timeout);
    else n_pass++;
    rst_n = 1'b0; #1; model_reset();
    n_chk++;
    if (o_cede_timeout !== 1'b0) $display("FAIL timeout_clear: got %b expected 0", o_cede_timeout);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    halt = 1'b1; mgr_req = 1'b1; mgr_we = 1'b1; mgr_ad = 19'h00055;
    tick(); #1;
    n_chk++;
    if ({o_mgr_gnt, o_mem_we} !== 2'b11)
      $display("FAIL async_pre: got gnt=%b we=%b expected 1 1", o_mgr_gnt, o_mem_we);
    else n_pass++;
    #2; rst_n = 1'b0; #1; model_reset();
    n_chk++;
    if ({o_mem_we, o_mgr_gnt, o_fsm} !== {1'b0, 1'b0, 3'd0})
      $display("FAIL async_reset: got we=%b gnt=%b fsm=%0d expected 0 0 0", o_mem_we, o_mgr_gnt, o_fsm);
    else n_pass++;
    tick();
    rst_n = 1'b1; mgr_req = 1'b0; halt = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0) mgr_req = ~mgr_req;
      if ($urandom_range(9) == 0) halt = ~halt;
      core_cede = ($urandom_range(3) == 0);
      core_we = 1'($urandom); mgr_we = 1'($urandom);
      core_wd = 8'($urandom); mgr_wd = 8'($urandom); mem_rd = 8'($urandom);
      core_ad = MABL'($urandom); mgr_ad = MABL'($urandom);
      #1;
      n_chk++;
      if (dut_outs() !== exp_outs())
        $display("FAIL random[%0d]: got %h expected %h", c, dut_outs(), exp_outs());
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_drain_handoff();
    test_handback();
    test_halt_loader();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
